// File: rtl/dmem_pkg.sv
// Shared types and sizing helpers for the data-memory bank.
// Sizes follow the bank's DATA_W/WAIT_CYCLES parameters.
package dmem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_t;

    function automatic int clog2_min1(input int v);
        return (v <= 2) ? 1 : $clog2(v);
    endfunction

    function automatic int f_bytes(input int data_w);
        return data_w / 8;
    endfunction

    function automatic int f_off_w(input int data_w);
        return $clog2(data_w / 8);
    endfunction

    function automatic int f_cnt_w(input int wait_cycles);
        return clog2_min1(wait_cycles + 1);
    endfunction

endpackage

// File: rtl/dmem_lane_array.sv
// DEPTH x DATA_W word storage with per-byte write enables
// and a registered read port that holds until the next read.
module dmem_lane_array
    import dmem_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int DEPTH  = 256,
    parameter int IDX_W  = 8
) (
    input  logic                  clk,
    input  logic                  i_we,
    input  logic                  i_re,
    input  logic [IDX_W-1:0]      i_idx,
    input  logic [DATA_W-1:0]     i_wdata,
    input  logic [DATA_W/8-1:0]   i_be,
    output logic [DATA_W-1:0]     o_rdata
);

    localparam int BYTES = f_bytes(DATA_W);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [DATA_W-1:0] r_rdata;

    always_ff @(posedge clk) begin
        if (i_we) begin
            for (int b = 0; b < BYTES; b++) begin
                if (i_be[b]) begin
                    r_mem[i_idx][8*b +: 8] <= i_wdata[8*b +: 8];
                end
            end
        end
        if (i_re) begin
            r_rdata <= r_mem[i_idx];
        end
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/dmem_hs_bank.sv
// Data-memory bank: valid/ready request, programmable wait states,
// one-shot response, misaligned/out-of-range flagging.
module dmem_hs_bank
    import dmem_pkg::*;
#(
    parameter int DATA_W      = 16,
    parameter int ADDR_W      = 16,
    parameter int DEPTH       = 256,
    parameter int WAIT_CYCLES = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [ADDR_W-1:0]     req_addr,
    input  logic [DATA_W-1:0]     req_wdata,
    input  logic [DATA_W/8-1:0]   req_be,
    output logic                  resp_valid,
    output logic [DATA_W-1:0]     resp_rdata,
    output logic                  resp_err
);

    localparam int BYTES = f_bytes(DATA_W);
    localparam int OFF_W = f_off_w(DATA_W);
    localparam int IDX_W = ADDR_W - OFF_W;
    localparam int MA_W  = clog2_min1(DEPTH);
    localparam int CNT_W = f_cnt_w(WAIT_CYCLES);

    // one extra bit so DEPTH == 2**IDX_W is still representable
    localparam logic [IDX_W:0]   DEPTH_V = (IDX_W+1)'(DEPTH);
    localparam logic [CNT_W-1:0] WAIT_V  = CNT_W'(WAIT_CYCLES);

    state_t r_state;
    state_t w_next;
    logic   w_accept;
    logic   w_access;

    logic [CNT_W-1:0]  r_cnt;
    logic              r_we;
    logic [MA_W-1:0]   r_idx;
    logic [DATA_W-1:0] r_wdata;
    logic [BYTES-1:0]  r_be;
    logic              r_err;
    logic              r_rd_ok;
    logic              r_resp_err;

    logic [IDX_W-1:0]  w_idx;
    logic              w_err;
    logic [DATA_W-1:0] w_arr_rdata;

    assign w_idx = req_addr[ADDR_W-1:OFF_W];
    assign w_err = (|req_addr[OFF_W-1:0]) || ({1'b0, w_idx} >= DEPTH_V);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next   = r_state;
        w_accept = 1'b0;
        w_access = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (req_valid) begin
                    w_accept = 1'b1;
                    w_next   = BUSY;
                end
            end
            BUSY: begin
                if (r_cnt == '0) begin
                    w_access = 1'b1;
                    w_next   = RESP;
                end
            end
            RESP: w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt      <= '0;
            r_we       <= 1'b0;
            r_idx      <= '0;
            r_wdata    <= '0;
            r_be       <= '0;
            r_err      <= 1'b0;
            r_rd_ok    <= 1'b0;
            r_resp_err <= 1'b0;
        end else begin
            if (w_accept) begin
                r_cnt   <= WAIT_V;
                r_we    <= req_we;
                r_idx   <= w_idx[MA_W-1:0];
                r_wdata <= req_wdata;
                r_be    <= req_be;
                r_err   <= w_err;
            end else if (r_state == BUSY && r_cnt != '0) begin
                r_cnt <= r_cnt - 1'b1;
            end
            if (w_access) begin
                r_rd_ok    <= !r_we && !r_err;
                r_resp_err <= r_err;
            end
        end
    end

    dmem_lane_array #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .IDX_W  (MA_W)
    ) u_array (
        .clk     (clk),
        .i_we    (w_access && r_we && !r_err),
        .i_re    (w_access && !r_we && !r_err),
        .i_idx   (r_idx),
        .i_wdata (r_wdata),
        .i_be    (r_be),
        .o_rdata (w_arr_rdata)
    );

    // the array's read register is only meaningful after a clean read
    assign req_ready  = (r_state == IDLE);
    assign resp_valid = (r_state == RESP);
    assign resp_err   = r_resp_err;
    assign resp_rdata = r_rd_ok ? w_arr_rdata : '0;

endmodule

// File: tb/tb_dmem_hs_bank.sv
// Self-checking bench for dmem_hs_bank against a word-array model.
// A second instance runs with zero wait states.
module tb_dmem_hs_bank;

    localparam int DW    = 16;
    localparam int AW    = 16;
    localparam int DEPTH = 256;
    localparam int WC    = 2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic          req_valid = 1'b0;
    logic          req_ready;
    logic          req_we = 1'b0;
    logic [AW-1:0] req_addr = '0;
    logic [DW-1:0] req_wdata = '0;
    logic [1:0]    req_be = '0;
    logic          resp_valid;
    logic [DW-1:0] resp_rdata;
    logic          resp_err;

    logic          v0 = 1'b0;
    logic          rdy0;
    logic          we0 = 1'b1;
    logic [AW-1:0] addr0 = '0;
    logic [DW-1:0] wd0 = '0;
    logic [1:0]    be0 = '0;
    logic          rv0;
    logic [DW-1:0] rd0;
    logic          er0;

    dmem_hs_bank #(
        .DATA_W(DW), .ADDR_W(AW), .DEPTH(DEPTH), .WAIT_CYCLES(WC)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_we(req_we), .req_addr(req_addr),
        .req_wdata(req_wdata), .req_be(req_be),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata),
        .resp_err(resp_err)
    );

    dmem_hs_bank #(
        .DATA_W(DW), .ADDR_W(AW), .DEPTH(DEPTH), .WAIT_CYCLES(0)
    ) dut0 (
        .clk(clk), .rst_n(rst_n),
        .req_valid(v0), .req_ready(rdy0),
        .req_we(we0), .req_addr(addr0),
        .req_wdata(wd0), .req_be(be0),
        .resp_valid(rv0), .resp_rdata(rd0),
        .resp_err(er0)
    );

    int n_tests = 0;
    int n_fail  = 0;
    logic [DW-1:0] mem_m [DEPTH];

    int cyc = 0;
    logic log_en = 1'b0;
    logic log0_en = 1'b0;
    int acc_q[$];
    int acc0_q[$];

    always @(posedge clk) begin
        if (log_en && req_valid && req_ready) acc_q.push_back(cyc);
        if (log0_en && v0 && rdy0) acc0_q.push_back(cyc);
        cyc++;
    end

    function automatic void model(input logic we, input logic [AW-1:0] addr,
                                  input logic [DW-1:0] wd, input logic [1:0] be,
                                  output logic [DW-1:0] rd, output logic er);
        int idx;
        idx = int'(addr) / 2;
        er = (addr % 2 != 0) || (idx >= DEPTH);
        rd = '0;
        if (!er) begin
            if (we) begin
                for (int b = 0; b < 2; b++)
                    if (be[b]) mem_m[idx][8*b +: 8] = wd[8*b +: 8];
            end else begin
                rd = mem_m[idx];
            end
        end
    endfunction

    // Drives one request and returns what the bank answered.
    task automatic do_req(input logic we, input logic [AW-1:0] addr,
                          input logic [DW-1:0] wd, input logic [1:0] be,
                          output logic [DW-1:0] rd, output logic er,
                          output int lat, output logic pulse1);
        int guard;
        @(negedge clk);
        req_we = we; req_addr = addr; req_wdata = wd; req_be = be;
        req_valid = 1'b1;
        guard = 0;
        while (!req_ready && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        @(negedge clk);
        req_valid = 1'b0;
        lat = 1;
        while (!resp_valid && lat < 50) begin
            @(negedge clk);
            lat++;
        end
        rd = resp_rdata;
        er = resp_err;
        @(negedge clk);
        pulse1 = !resp_valid && (resp_rdata === rd) && (resp_err === er);
    endtask

    task automatic test_reset();
        #12;
        n_tests++;
        if ({req_ready, resp_valid, resp_rdata, resp_err} !== {1'b1, 1'b0, 16'h0, 1'b0}) begin
            n_fail++;
            $display("FAIL reset_init: got rdy=%b v=%b d=%h e=%b want 1 0 0000 0",
                     req_ready, resp_valid, resp_rdata, resp_err);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_init();
        logic [DW-1:0] rd, erd;
        logic er, eer, p;
        int lat;
        int bad = 0;
        for (int i = 0; i < DEPTH; i++) begin
            do_req(1'b1, AW'(2 * i), '0, 2'b11, rd, er, lat, p);
            model(1'b1, AW'(2 * i), '0, 2'b11, erd, eer);
            if (rd !== erd || er !== eer || lat != WC + 2 || !p) bad++;
        end
        n_tests++;
        if (bad != 0) begin
            n_fail++;
            $display("FAIL init_writes: %0d bad responses, want 0", bad);
        end
    endtask

    task automatic test_basic();
        logic [DW-1:0] rd, erd;
        logic er, eer, p;
        int lat;
        do_req(1'b1, 16'h0002, 16'h0020, 2'b11, rd, er, lat, p);
        model(1'b1, 16'h0002, 16'h0020, 2'b11, erd, eer);
        n_tests++;
        if (lat != WC + 2 || !p || rd !== erd || er !== eer) begin
            n_fail++;
            $display("FAIL basic_write: lat=%0d p=%b d=%h e=%b want lat=%0d p=1 d=%h e=%b",
                     lat, p, rd, er, WC + 2, erd, eer);
        end
        do_req(1'b0, 16'h0002, 16'h0, 2'b00, rd, er, lat, p);
        model(1'b0, 16'h0002, 16'h0, 2'b00, erd, eer);
        n_tests++;
        if (rd !== 16'h0020 || rd !== erd || er !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_read: got d=%h e=%b want d=0020 e=0", rd, er);
        end
        n_tests++;
        if (lat != WC + 2 || !p) begin
            n_fail++;
            $display("FAIL basic_timing: lat=%0d pulse1=%b want lat=%0d pulse1=1", lat, p, WC + 2);
        end
    endtask

    task automatic test_async_reset();
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        n_tests++;
        if ({req_ready, resp_valid, resp_rdata, resp_err} !== {1'b1, 1'b0, 16'h0, 1'b0}) begin
            n_fail++;
            $display("FAIL reset_async: got rdy=%b v=%b d=%h e=%b want 1 0 0000 0",
                     req_ready, resp_valid, resp_rdata, resp_err);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_lanes();
        logic [DW-1:0] rd, erd;
        logic er, eer, p;
        int lat;
        int nresp = 0;
        do_req(1'b1, 16'h0004, 16'h1234, 2'b11, rd, er, lat, p);
        model(1'b1, 16'h0004, 16'h1234, 2'b11, erd, eer);
        if (lat != WC + 2 || !p) nresp++;
        do_req(1'b1, 16'h0004, 16'hABCD, 2'b01, rd, er, lat, p);
        model(1'b1, 16'h0004, 16'hABCD, 2'b01, erd, eer);
        if (lat != WC + 2 || !p) nresp++;
        do_req(1'b1, 16'h0004, 16'hFFFF, 2'b00, rd, er, lat, p);
        model(1'b1, 16'h0004, 16'hFFFF, 2'b00, erd, eer);
        if (lat != WC + 2 || !p) nresp++;
        n_tests++;
        if (nresp != 0) begin
            n_fail++;
            $display("FAIL lanes_resp: %0d writes without a clean response, want 0", nresp);
        end
        do_req(1'b0, 16'h0004, 16'h0, 2'b00, rd, er, lat, p);
        model(1'b0, 16'h0004, 16'h0, 2'b00, erd, eer);
        n_tests++;
        if (rd !== 16'h12CD || rd !== erd || er !== 1'b0) begin
            n_fail++;
            $display("FAIL lanes_read: got d=%h e=%b want d=12cd e=0", rd, er);
        end
    endtask

    task automatic test_errors();
        logic [DW-1:0] rd, erd;
        logic er, eer, p;
        int lat;
        do_req(1'b1, 16'h0003, 16'hBEEF, 2'b11, rd, er, lat, p);
        model(1'b1, 16'h0003, 16'hBEEF, 2'b11, erd, eer);
        n_tests++;
        if (er !== 1'b1 || rd !== 16'h0 || lat != WC + 2 || !p) begin
            n_fail++;
            $display("FAIL err_misalign: got e=%b d=%h lat=%0d want e=1 d=0000 lat=%0d",
                     er, rd, lat, WC + 2);
        end
        do_req(1'b0, 16'h0002, 16'h0, 2'b00, rd, er, lat, p);
        model(1'b0, 16'h0002, 16'h0, 2'b00, erd, eer);
        n_tests++;
        if (rd !== erd || er !== 1'b0) begin
            n_fail++;
            $display("FAIL err_no_write: mem[1] got %h e=%b want %h e=0", rd, er, erd);
        end
        do_req(1'b0, 16'h0200, 16'h0, 2'b00, rd, er, lat, p);
        n_tests++;
        if (er !== 1'b1 || rd !== 16'h0) begin
            n_fail++;
            $display("FAIL err_range: got e=%b d=%h want e=1 d=0000", er, rd);
        end
        do_req(1'b0, 16'h0004, 16'h0, 2'b00, rd, er, lat, p);
        model(1'b0, 16'h0004, 16'h0, 2'b00, erd, eer);
        n_tests++;
        if (er !== 1'b0 || rd !== erd) begin
            n_fail++;
            $display("FAIL err_recover: got e=%b d=%h want e=0 d=%h", er, rd, erd);
        end
    endtask

    task automatic test_reset_midop();
        logic [DW-1:0] rd, erd;
        logic er, eer, p;
        int lat;
        int seen = 0;
        @(negedge clk);
        req_we = 1'b1; req_addr = 16'h0006; req_wdata = 16'hFFFF; req_be = 2'b11;
        req_valid = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (8) begin
            @(negedge clk);
            if (resp_valid) seen++;
        end
        n_tests++;
        if (seen != 0) begin
            n_fail++;
            $display("FAIL midop_noresp: resp_valid seen %0d times, want 0", seen);
        end
        do_req(1'b0, 16'h0006, 16'h0, 2'b00, rd, er, lat, p);
        model(1'b0, 16'h0006, 16'h0, 2'b00, erd, eer);
        n_tests++;
        if (rd !== 16'h0000 || rd !== erd || er !== 1'b0) begin
            n_fail++;
            $display("FAIL midop_nowrite: got d=%h e=%b want d=0000 e=0", rd, er);
        end
    endtask

    task automatic test_random();
        logic [DW-1:0] rd, erd, wd;
        logic er, eer, p, we;
        logic [AW-1:0] addr;
        logic [1:0] be;
        int lat;
        for (int i = 0; i < 60; i++) begin
            we = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 4) == 0) addr = AW'($urandom);
            else addr = AW'(2 * $urandom_range(0, 15));
            wd = DW'($urandom);
            be = 2'($urandom);
            do_req(we, addr, wd, be, rd, er, lat, p);
            model(we, addr, wd, be, erd, eer);
            n_tests++;
            if ({rd, er, p} !== {erd, eer, 1'b1} || lat != WC + 2) begin
                n_fail++;
                $display("FAIL rand_%0d: we=%b a=%h got d=%h e=%b lat=%0d p=%b want d=%h e=%b lat=%0d p=1",
                         i, we, addr, rd, er, lat, p, erd, eer, WC + 2);
            end
        end
    endtask

    task automatic test_back_to_back();
        int exp_q[$];
        int base;
        for (int k = 0; k < 20; k += WC + 3) exp_q.push_back(k);
        acc_q.delete();
        @(negedge clk);
        req_we = 1'b0; req_addr = 16'h0000; req_valid = 1'b1;
        log_en = 1'b1;
        repeat (20) @(negedge clk);
        req_valid = 1'b0;
        log_en = 1'b0;
        repeat (10) @(negedge clk);
        base = (acc_q.size() > 0) ? acc_q[0] : 0;
        foreach (acc_q[i]) acc_q[i] = acc_q[i] - base;
        n_tests++;
        if (acc_q != exp_q) begin
            n_fail++;
            $display("FAIL throughput: got %0d accepts %p want %p", acc_q.size(), acc_q, exp_q);
        end
    endtask

    task automatic test_wait0();
        int lat;
        int exp_q[$];
        int base;
        @(negedge clk);
        we0 = 1'b1; addr0 = 16'h0008; wd0 = 16'h5A5A; be0 = 2'b11;
        v0 = 1'b1;
        @(negedge clk);
        v0 = 1'b0;
        lat = 1;
        while (!rv0 && lat < 50) begin
            @(negedge clk);
            lat++;
        end
        n_tests++;
        if (lat != 2 || rd0 !== 16'h0 || er0 !== 1'b0) begin
            n_fail++;
            $display("FAIL wait0_latency: lat=%0d d=%h e=%b want lat=2 d=0000 e=0", lat, rd0, er0);
        end
        for (int k = 0; k < 20; k += 3) exp_q.push_back(k);
        acc0_q.delete();
        repeat (2) @(negedge clk);
        v0 = 1'b1;
        log0_en = 1'b1;
        repeat (20) @(negedge clk);
        v0 = 1'b0;
        log0_en = 1'b0;
        repeat (5) @(negedge clk);
        base = (acc0_q.size() > 0) ? acc0_q[0] : 0;
        foreach (acc0_q[i]) acc0_q[i] = acc0_q[i] - base;
        n_tests++;
        if (acc0_q != exp_q) begin
            n_fail++;
            $display("FAIL wait0_throughput: got %p want %p", acc0_q, exp_q);
        end
    endtask

    initial begin
        test_reset();
        test_init();
        test_basic();
        test_async_reset();
        test_lanes();
        test_errors();
        test_reset_midop();
        test_random();
        test_back_to_back();
        test_wait0();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
